// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states, requester ids.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store data/byte-enables, load extraction/extension, misalign detect.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [31:0] din,
    output logic [3:0]  we_mask,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata_raw[8*addr_lo +: 8];
        half_sel  = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
        din       = wdata;
        we_mask   = 4'b1111;
        rdata_ext = rdata_raw;
        misalign  = (addr_lo != 2'b00);
        case (size)
            SZ_BYTE: begin
                din       = {4{wdata[7:0]}};
                we_mask   = 4'b0001 << addr_lo;
                rdata_ext = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                misalign  = 1'b0;
            end
            SZ_HALF: begin
                din       = {2{wdata[15:0]}};
                we_mask   = addr_lo[1] ? 4'b1100 : 4'b0011;
                rdata_ext = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                misalign  = addr_lo[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_controller.sv
// Data-RAM sequencer/arbiter for MEM-stage loads/stores and debug word reads.
// Optional debug port and round-robin arbitration enabled by defining DMEM_DEBUG_PORT_EN.
module data_mem_controller
    import dmem_pkg::*;
#(
    parameter int NB_ADDR   = 32,
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int NB_WADDR  = 10
) (
    input  logic                clka,
    input  logic                rsta,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [1:0]          cpu_size,
    input  logic                cpu_unsigned,
    input  logic [NB_ADDR-1:0]  cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_ack,
    output logic                cpu_misalign,
    input  logic                dbg_req,
    input  logic [NB_ADDR-1:0]  dbg_addr,
    output logic [31:0]         dbg_rdata,
    output logic                dbg_ack,
    output logic                ram_en,
    output logic [NB_COL-1:0]   ram_we,
    output logic [NB_WADDR-1:0] ram_addr,
    output logic [31:0]         ram_din,
    input  logic [31:0]         ram_dout
);

    state_e              state_q, state_d;
    logic                gnt_id_q, gnt_id_d;
    logic [NB_WADDR+1:0] addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                we_q, we_d;
    logic                uns_q, uns_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                dbg_ack_q, dbg_ack_d;
    logic                misalign_q, misalign_d;
    logic [31:0]         cpu_rdata_q, cpu_rdata_d;
    logic [31:0]         dbg_rdata_q, dbg_rdata_d;
`ifdef DMEM_DEBUG_PORT_EN
    logic                last_grant_q, last_grant_d;
`endif

    logic        cpu_win, dbg_win, access;
    logic [1:0]  al_size, al_lo;
    logic [31:0] al_din, al_rdata;
    logic [3:0]  al_we;
    logic        al_misalign;

    // In IDLE the aligner sees the live CPU request so misalignment is known at grant.
    assign al_size = (state_q == ST_IDLE) ? cpu_size       : size_q;
    assign al_lo   = (state_q == ST_IDLE) ? cpu_addr[1:0]  : addr_q[1:0];

    dmem_lane_align u_align (
        .size        (al_size),
        .addr_lo     (al_lo),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata_raw   (ram_dout),
        .din         (al_din),
        .we_mask     (al_we),
        .rdata_ext   (al_rdata),
        .misalign    (al_misalign)
    );

`ifdef DMEM_DEBUG_PORT_EN
    assign dbg_win = dbg_req && (!cpu_req || last_grant_q == REQ_CPU);
    assign cpu_win = cpu_req && !dbg_win;
`else
    assign dbg_win = 1'b0;
    assign cpu_win = cpu_req;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        addr_d      = addr_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        misalign_d  = 1'b0;
        cpu_rdata_d = '0;
        dbg_rdata_d = '0;
`ifdef DMEM_DEBUG_PORT_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_win) begin
                    gnt_id_d = REQ_CPU;
                    addr_d   = cpu_addr[NB_WADDR+1:0];
                    size_d   = cpu_size;
                    we_d     = cpu_we;
                    uns_d    = cpu_unsigned;
                    wdata_d  = cpu_wdata;
`ifdef DMEM_DEBUG_PORT_EN
                    last_grant_d = REQ_CPU;
`endif
                    if (al_misalign) begin
                        state_d    = ST_DONE;
                        cpu_ack_d  = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end else if (dbg_win) begin
                    gnt_id_d = REQ_DBG;
                    addr_d   = dbg_addr[NB_WADDR+1:0];
                    size_d   = SZ_WORD;
                    we_d     = 1'b0;
                    uns_d    = 1'b0;
                    wdata_d  = '0;
`ifdef DMEM_DEBUG_PORT_EN
                    last_grant_d = REQ_DBG;
`endif
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                if (gnt_id_q == REQ_CPU) begin
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = we_q ? '0 : al_rdata;
                end else begin
                    dbg_ack_d   = 1'b1;
                    dbg_rdata_d = ram_dout;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q     <= ST_IDLE;
            gnt_id_q    <= REQ_CPU;
            addr_q      <= '0;
            size_q      <= SZ_WORD;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            misalign_q  <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
`ifdef DMEM_DEBUG_PORT_EN
            last_grant_q <= REQ_DBG;
`endif
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            misalign_q  <= misalign_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
`ifdef DMEM_DEBUG_PORT_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // rsta gates the RAM port combinationally so a reset mid-ACCESS cannot write.
    assign access   = (state_q == ST_ACCESS) && !rsta;
    assign ram_en   = access;
    assign ram_we   = (access && we_q) ? al_we : '0;
    assign ram_addr = rsta ? '0 : addr_q[NB_WADDR+1:2];
    assign ram_din  = access ? al_din : '0;

    assign cpu_ack      = cpu_ack_q;
    assign cpu_misalign = misalign_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign dbg_ack      = dbg_ack_q;
    assign dbg_rdata    = dbg_rdata_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed self-checking bench for data_mem_controller with a behavioural byte-lane RAM.
module tb_data_mem_controller;

    logic        clka = 1'b0;
    logic        rsta;
    logic        cpu_req, cpu_we, cpu_unsigned;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_misalign;
    logic        dbg_req;
    logic [31:0] dbg_addr, dbg_rdata;
    logic        dbg_ack;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clka = ~clka;

    data_mem_controller #(.NB_ADDR(32), .NB_COL(4), .COL_WIDTH(8), .NB_WADDR(10)) dut (
        .clka(clka), .rsta(rsta),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .cpu_misalign(cpu_misalign),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // RAM samples on the falling edge, so dout is ready at the rising edge ending ACCESS.
    logic [31:0] mem [0:1023];
    always @(negedge clka) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One CPU transaction; lat = edges from request to ack (0 = timed out).
    task automatic cpu_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output logic mis,
                          output int en_cnt, output logic [3:0] we_seen,
                          output logic [31:0] din_seen, output logic [9:0] addr_seen);
        rd = '0; lat = 0; mis = 1'b0; en_cnt = 0; we_seen = '0; din_seen = '0; addr_seen = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_unsigned = uns;
        cpu_addr = addr; cpu_wdata = wd;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clka); #1;
            if (ram_en) begin
                en_cnt++; we_seen = ram_we; din_seen = ram_din; addr_seen = ram_addr;
            end
            if (cpu_ack) begin
                lat = k; rd = cpu_rdata; mis = cpu_misalign;
                break;
            end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(posedge clka); #1;
    endtask

    logic [31:0] rd, din_s;
    logic [3:0]  we_s;
    logic [9:0]  addr_s;
    logic        mis;
    int          lat, en_cnt;
    int          acks, dbg_acks, prev_cyc;
    logic        who [0:3];
    int          cyc [0:3];

    initial begin
        rsta = 1'b1; cpu_req = 1'b0; cpu_we = 1'b1; cpu_size = 2'b10; cpu_unsigned = 1'b0;
        cpu_addr = 32'h0000_0104; cpu_wdata = 32'h5A5A_5A5A; dbg_req = 1'b0; dbg_addr = '0;
        repeat (3) @(posedge clka);
        #1;
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_ram_we", {28'd0, ram_we}, 32'd0);
        check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        check("rst_ram_din", ram_din, 32'd0);
        check("rst_acks", {30'd0, cpu_ack, dbg_ack}, 32'd0);
        check("rst_misalign", {31'd0, cpu_misalign}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'd0);
        rsta = 1'b0;
        @(posedge clka); #1;

        cpu_op(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        cpu_op(1'b1, 2'b00, 1'b0, 32'h103, 32'hAB, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("sb_we", {28'd0, we_s}, 32'h8);
        check("sb_din", din_s, 32'hABABABAB);
        check("sb_addr", {22'd0, addr_s}, 32'h40);
        check("sb_latency", lat, 2);
        cpu_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("lw_after_sb", rd, 32'hAB000000);
        check("lw_we_zero", {28'd0, we_s}, 32'h0);
        cpu_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("lb_103", rd, 32'hFFFFFFAB);

        cpu_op(1'b1, 2'b10, 1'b0, 32'h40, 32'h80F0FF7F, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("sw_we", {28'd0, we_s}, 32'hF);
        check("sw_addr", {22'd0, addr_s}, 32'h10);
        cpu_op(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("lb_41", rd, 32'hFFFFFFFF);
        check("lb_41_misalign", {31'd0, mis}, 32'd0);
        cpu_op(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("lbu_41", rd, 32'h000000FF);
        cpu_op(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("lh_42", rd, 32'hFFFF80F0);
        cpu_op(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("lhu_42", rd, 32'h000080F0);
        cpu_op(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("lb_40_pos", rd, 32'h0000007F);

        cpu_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        cpu_op(1'b1, 2'b01, 1'b0, 32'h22, 32'hCAFE1234, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("sh_we", {28'd0, we_s}, 32'hC);
        check("sh_din", din_s, 32'h12341234);
        cpu_op(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("lw_size11", rd, 32'h12340000);

        cpu_op(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("mis_lw_latency", lat, 1);
        check("mis_lw_flag", {31'd0, mis}, 32'd1);
        check("mis_lw_rdata", rd, 32'd0);
        check("mis_lw_no_en", en_cnt, 0);
        cpu_op(1'b1, 2'b01, 1'b0, 32'h41, 32'h5555, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("mis_sh_flag", {31'd0, mis}, 32'd1);
        check("mis_sh_no_en", en_cnt, 0);
        cpu_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("lw_40_untouched", rd, 32'h80F0FF7F);

        // Reset during the ACCESS cycle of a store.
        cpu_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        @(posedge clka); #1;
        check("pre_rst_access_en", {31'd0, ram_en}, 32'd1);
        rsta = 1'b1;
        #1;
        check("rst_access_we", {28'd0, ram_we}, 32'd0);
        check("rst_access_en", {31'd0, ram_en}, 32'd0);
        @(posedge clka); #1;
        rsta = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clka); #1;
            if (cpu_ack || dbg_ack) acks++;
        end
        check("rst_access_no_ack", acks, 0);
        cpu_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, lat, mis, en_cnt, we_s, din_s, addr_s);
        check("lw_10_old", rd, 32'h11223344);

        // Both requesters held high after a fresh reset.
        rsta = 1'b1;
        @(posedge clka); #1;
        rsta = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_unsigned = 1'b0; cpu_addr = 32'h40;
        dbg_req = 1'b1; dbg_addr = 32'h23;
        acks = 0; dbg_acks = 0;
        for (int k = 0; k < 4; k++) begin who[k] = 1'b0; cyc[k] = 0; end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clka); #1;
            if (cpu_ack && dbg_ack) check("both_acks_together", 32'd1, 32'd0);
            if (cpu_ack) check("arb_cpu_rdata", cpu_rdata, 32'h80F0FF7F);
            if (dbg_ack) begin
                dbg_acks++;
                check("arb_dbg_rdata", dbg_rdata, 32'h12340000);
            end
            if ((cpu_ack || dbg_ack) && acks < 4) begin
                who[acks] = dbg_ack; cyc[acks] = k; acks++;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        check("arb_ack_count", acks, 4);
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_DEBUG_PORT_EN
            check("arb_winner", {31'd0, who[k]}, {31'd0, k[0]});
`else
            check("arb_winner", {31'd0, who[k]}, 32'd0);
`endif
            check("arb_spacing", cyc[k] - prev_cyc, (k == 0) ? 2 : 3);
            prev_cyc = cyc[k];
        end
`ifndef DMEM_DEBUG_PORT_EN
        check("nodbg_no_dbg_ack", dbg_acks, 0);
`endif
        repeat (3) @(posedge clka);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
